seq_pattern_detector: RTL

Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the team's fixed-pattern serial detectors. Pattern value, pattern length (1..MAX_LEN) and overlap mode are loaded at run time, input bits are qualified by a valid strobe, and matches are counted in a saturating counter. It sits on a serial bit stream behind a deserialiser or line decoder and flags framing or sync words to downstream control logic.

---
 rtl/seq_pattern_detector_if.sv | 34 +++
 rtl/seq_pattern_detector.sv | 114 +++++++++++
 2 files changed

// File: rtl/seq_pattern_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector_if
// Description : Serial bit stream, configuration and match-status bundle for
//               the programmable serial pattern detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_pattern_detector_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               bit_valid;
   logic               bit_in;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               clr_count;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               count_sat;

   modport master (
      output bit_valid, bit_in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      input  match, match_count, count_sat
   );

   modport slave (
      input  bit_valid, bit_in, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      output match, match_count, count_sat
   );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Runtime-programmable serial pattern detector with valid-qualified
//               input, overlap control and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_pattern_detector_if.slave bus
);
   localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = C_CNT_MAX - CNT_W'(1);

   // The oldest history bit shifts out before it could ever be compared, so
   // only MAX_LEN-1 bits are stored; the incoming bit completes the window.
   logic [MAX_LEN-2:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;

   logic [MAX_LEN-1:0] hist_n;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   fill_n;
   logic               hit;

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
   end

   always_comb begin
      hist_n = {hist_q, bus.bit_in};
      fill_n = (fill_q == C_MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
      hit    = bus.bit_valid && (len_q != '0) && (fill_n >= len_q) &&
               (((hist_n ^ pat_q) & mask) == '0);
   end

   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      sat_d   = sat_q;

      if (bus.cfg_load) begin
         pat_d  = bus.cfg_pattern;
         len_d  = (bus.cfg_len > C_MAX_LEN) ? C_MAX_LEN : bus.cfg_len;
         ovl_d  = bus.cfg_overlap;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
         sat_d  = 1'b0;
      end else begin
         if (bus.bit_valid) begin
            hist_d = hist_n[MAX_LEN-2:0];
            fill_d = (hit && !ovl_q) ? '0 : fill_n;
         end
         if (hit) begin
            match_d = 1'b1;
         end
         if (bus.clr_count) begin
            cnt_d = '0;
            sat_d = 1'b0;
         end else if (hit && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
            sat_d = sat_q | (cnt_q == C_CNT_LAST);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b1;
         match_q <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.match       = match_q;
   assign bus.match_count = cnt_q;
   assign bus.count_sat   = sat_q;

endmodule
`default_nettype wire
